// File: rtl/i2s_pkg.sv
// i2s_pkg
//   Definitions shared by the I2S transmitter, receiver and APB wrapper.
//   - i2s_tx_state_t   : transmit serializer FSM state
//   - I2S_DATA_W_DEF   : default bits per channel
//   - I2S_CLK_DIV_DEF  : default clk cycles per SCK half-period
package i2s_pkg;

    localparam int I2S_DATA_W_DEF  = 16;
    localparam int I2S_CLK_DIV_DEF = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_tx_state_t;

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if
//   Groups the TX FIFO read side and the I2S pin side of the serializer.
//   Signals:
//     fifo_empty  FIFO empty flag
//     fifo_data   FIFO head word (first-word-fall-through), {left, right}
//     fifo_rd     single-cycle pop strobe
//     i2s_sck     bit clock
//     i2s_ws      word select (0 = left, 1 = right)
//     i2s_sd      serial data, MSB first
//   Modports:
//     master  the serializer (reads the FIFO, drives the pins)
//     slave   the FIFO / pin environment
interface i2s_tx_serializer_if
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W_DEF
);
    logic                  fifo_empty;
    logic [2*DATA_W-1:0]   fifo_data;
    logic                  fifo_rd;
    logic                  i2s_sck;
    logic                  i2s_ws;
    logic                  i2s_sd;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        output i2s_sck,
        output i2s_ws,
        output i2s_sd
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        input  i2s_sck,
        input  i2s_ws,
        input  i2s_sd
    );
endinterface

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen
//   Bit-clock divider. sck toggles every CLK_DIV clk cycles while clear is low.
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-low reset
//     clear     hold divider at zero with sck low
//     sck       registered bit clock
//     sck_rise  high in the cycle whose closing clk edge drives sck 0->1
//     sck_fall  high in the cycle whose closing clk edge drives sck 1->0
module i2s_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase_end;

    assign phase_end = (cnt == CNT_MAX);

    // Ticks look ahead one cycle so the consumer can act on the same edge
    // that moves sck.
    assign sck_rise = !clear && phase_end && !sck;
    assign sck_fall = !clear && phase_end &&  sck;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (phase_end) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Drains {left, right} words from the TX FIFO and drives the I2S bus.
//   One FIFO word is popped per frame; an empty FIFO at a frame start sends
//   a zero frame and pulses underrun. Disabling stops at the next frame
//   boundary after the frame in flight completes.
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous active-low reset
//     enable        1 = run, 0 = stop at next frame boundary
//     bus           i2s_tx_serializer_if.master (FIFO read side + I2S pins)
//     busy          1 while in RUN
//     underrun      one-cycle pulse when a frame starts with the FIFO empty
//     underrun_cnt  saturating underrun count (only with the macro below)
//   Build option:
//     I2S_TX_UNDERRUN_CNT_EN  adds the 16-bit underrun_cnt output
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int DATA_W  = I2S_DATA_W_DEF,
    parameter int CLK_DIV = I2S_CLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    i2s_tx_serializer_if.master bus,
    output logic                busy,
    output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);
    localparam int FRAME_BITS = 2 * DATA_W;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    i2s_tx_state_t          state, state_next;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BIT_W-1:0]       bit_next;
    logic [FRAME_BITS-1:0]  shreg;
    logic                   ws_q;

    logic sck;
    logic sck_fall;
    logic sck_rise_unused;   // transmitter only acts on falling edges

    logic fifo_rd_c;
    logic underrun_c;
    logic load_word;
    logic load_zero;
    logic go_idle;
    logic frame_end;

    // WS leads the channel by one bit: it is high from the last left bit up
    // to the second-to-last right bit.
    function automatic logic ws_for_bit(input int k);
        return (k >= DATA_W - 1) && (k <= 2 * DATA_W - 2);
    endfunction

    i2s_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == IDLE),
        .sck      (sck),
        .sck_rise (sck_rise_unused),
        .sck_fall (sck_fall)
    );

    assign bit_next  = bit_cnt + 1'b1;
    assign frame_end = (state == RUN) && sck_fall && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_rd_c  = 1'b0;
        underrun_c = 1'b0;
        load_word  = 1'b0;
        load_zero  = 1'b0;
        go_idle    = 1'b0;
        unique case (state)
            IDLE: begin
                // rst gates the start so no pop is issued while held in reset
                if (rst && enable && !bus.fifo_empty) begin
                    state_next = RUN;
                    fifo_rd_c  = 1'b1;
                    load_word  = 1'b1;
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (!enable) begin
                        state_next = IDLE;
                        go_idle    = 1'b1;
                    end else if (!bus.fifo_empty) begin
                        fifo_rd_c  = 1'b1;
                        load_word  = 1'b1;
                    end else begin
                        underrun_c = 1'b1;
                        load_zero  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            ws_q    <= 1'b1;
        end else if (load_word) begin
            bit_cnt <= '0;
            shreg   <= bus.fifo_data;
            ws_q    <= ws_for_bit(0);
        end else if (load_zero) begin
            bit_cnt <= '0;
            shreg   <= '0;
            ws_q    <= ws_for_bit(0);
        end else if (go_idle) begin
            bit_cnt <= '0;
            shreg   <= '0;
            ws_q    <= 1'b1;
        end else if (state == RUN && sck_fall) begin
            bit_cnt <= bit_next;
            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            ws_q    <= ws_for_bit(int'(bit_next));
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= '0;
        end else if (underrun_c && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

    assign bus.fifo_rd = fifo_rd_c;
    assign bus.i2s_sck = sck;
    assign bus.i2s_ws  = ws_q;
    assign bus.i2s_sd  = shreg[FRAME_BITS-1];
    assign busy        = (state == RUN);
    assign underrun    = underrun_c;
endmodule
